i2c_target_regfile: RTL and testbench



---
 rtl/i2c_target_regfile.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with an auto-incrementing byte-wide register file
// Ports: clk/reset (sync, active-high); scl_i/sda_i async pad inputs; sda_oe pulls SDA low;
// reg_q flat register file (reg k at [8k+7:8k]); wr_strobe/wr_index one-clk write notice;
// busy high from address match until STOP or return to IDLE.
// Optional: define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-cycle persistence filter per line.
module i2c_target_regfile #(
  parameter logic [6:0] ADDRESS    = 7'h69,
  parameter int         NUM_REGS   = 16,
  parameter int         PTR_W      = $clog2(NUM_REGS),
  parameter int         FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  state_t                   state_q, state_d;
  logic [1:0]               scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                     scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic                     scl_c, sda_c;
  logic [3:0]               cnt_q, cnt_d;
  logic [7:0]               sh_q, sh_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d, ptr_inc, wr_index_q, wr_index_d;
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;
  logic                     rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic                     wr_strobe_q, wr_strobe_d;
  logic                     scl_rise, scl_fall, start, stop, rx_done, load;
  assign scl_sync_d = {scl_sync_q[0], scl_i};
  assign sda_sync_d = {sda_sync_q[0], sda_i};
`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic          scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  // A filtered level only follows the synchronised one after FILTER_LEN consecutive differing samples.
  always_comb begin
    scl_cnt_d = (scl_sync_q[1] == scl_flt_q || scl_cnt_q == CW'(FILTER_LEN - 1)) ? '0 : scl_cnt_q + 1'b1;
    scl_flt_d = (scl_cnt_q == CW'(FILTER_LEN - 1)) ? scl_sync_q[1] : scl_flt_q;
    sda_cnt_d = (sda_sync_q[1] == sda_flt_q || sda_cnt_q == CW'(FILTER_LEN - 1)) ? '0 : sda_cnt_q + 1'b1;
    sda_flt_d = (sda_cnt_q == CW'(FILTER_LEN - 1)) ? sda_sync_q[1] : sda_flt_q;
  end
  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif
  assign scl_prev_d = scl_c;
  assign sda_prev_d = sda_c;
  assign scl_rise   = scl_c & ~scl_prev_q;
  assign scl_fall   = ~scl_c & scl_prev_q;
  assign start      = scl_c & scl_prev_q & ~sda_c & sda_prev_q;
  assign stop       = scl_c & scl_prev_q & sda_c & ~sda_prev_q;
  assign rx_done    = scl_fall && cnt_q == 4'd8;
  assign ptr_inc    = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    regs_d      = regs_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    load        = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
        sh_d  = {sh_q[6:0], sda_c};
        cnt_d = cnt_q + 4'd1;
      end
      case (state_q)
        ADDR: if (rx_done) begin
          cnt_d = '0;
          if (sh_q[7:1] == ADDRESS && sh_q[7:1] != 7'h00) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = sh_q[0];
          end else state_d = IDLE;
        end
        ADDR_ACK: if (scl_fall) begin
          if (rw_q) load = 1'b1;
          else begin
            state_d  = PTR;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end
        PTR: if (rx_done) begin
          cnt_d = '0;
          if ({1'b0, sh_q} < 9'(NUM_REGS)) begin
            ptr_d    = sh_q[PTR_W-1:0];
            sda_oe_d = 1'b1;
            state_d  = PTR_ACK;
          end else state_d = WAIT_STOP;
        end
        PTR_ACK: if (scl_fall) begin
          state_d  = WDATA;
          sda_oe_d = 1'b0;
        end
        WDATA: if (rx_done) begin
          regs_d[ptr_q] = sh_q;
          wr_strobe_d   = 1'b1;
          wr_index_d    = ptr_q;
          ptr_d         = ptr_inc;
          sda_oe_d      = 1'b1;
          cnt_d         = '0;
          state_d       = PTR_ACK;
        end
        RDATA: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = RDATA_ACK;
          end else begin
            sh_d     = {sh_q[6:0], 1'b0};
            sda_oe_d = ~sh_q[6];
            cnt_d    = cnt_q + 4'd1;
          end
        end
        // The shifter is idle here, so its LSB holds the master's ACK/NACK bit.
        RDATA_ACK: if (scl_rise) sh_d[0] = sda_c;
          else if (scl_fall) begin
            if (sh_q[0]) state_d = WAIT_STOP;
            else load = 1'b1;
          end
        IDLE, WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
      // Pointer advances as each byte is loaded, so a later read continues after the last byte sent.
      if (load) begin
        sh_d     = regs_q[ptr_q];
        sda_oe_d = ~regs_q[ptr_q][7];
        ptr_d    = ptr_inc;
        cnt_d    = 4'd1;
        state_d  = RDATA;
      end
    end
    if (state_d == IDLE) busy_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      cnt_q       <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      regs_q      <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
`ifdef I2C_GLITCH_FILTER_EN
      scl_flt_q   <= 1'b1;
      sda_flt_q   <= 1'b1;
      scl_cnt_q   <= '0;
      sda_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      regs_q      <= regs_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
`ifdef I2C_GLITCH_FILTER_EN
      scl_flt_q   <= scl_flt_d;
      sda_flt_q   <= sda_flt_d;
      scl_cnt_q   <= scl_cnt_d;
      sda_cnt_q   <= sda_cnt_d;
`endif
    end
  end
  assign sda_oe    = sda_oe_q;
  assign reg_q     = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: random I2C master traffic against a byte-array model of the target
module tb_i2c_target_regfile;
  localparam int N = 16;
  localparam int Q = 8;
  logic           clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic           sda_oe, wr_strobe, busy, sda_line;
  logic [8*N-1:0] reg_q;
  logic [3:0]     wr_index;
  int             n_checks = 0, n_pass = 0;
  logic [7:0]     mregs [N];
  int             mptr = 0;
  int             wlog [1024];
  int             wn = 0;
  int             oe_cnt = 0;
  logic [7:0]     tx_q [$];
  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_target_regfile #(.ADDRESS(7'h69), .NUM_REGS(N), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .reg_q(reg_q), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );
  always @(negedge clk) begin
    if (wr_strobe && wn < 1024) begin
      wlog[wn] = int'(wr_index);
      wn++;
    end
    if (sda_oe) oe_cnt++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_regs();
    logic [8*N-1:0] e;
    for (int k = 0; k < N; k++) e[8*k +: 8] = mregs[k];
    check("regs", reg_q, e);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask
  task automatic i2c_bit(input bit b, input int glen, output bit s);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    s = sda_line;
    if (glen > 0) begin
      sda_m = 1'b0; wait_clk(glen);
      sda_m = b;
    end
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask
  task automatic wr_byte(input logic [7:0] d, input int glen, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], (i == 7) ? glen : 0, s);
    i2c_bit(1'b1, 0, s);
    ack = ~s;
  endtask
  task automatic rd_byte(input bit nack, output logic [7:0] d);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 0, s);
      d[i] = s;
    end
    i2c_bit(nack, 0, s);
  endtask
  task automatic txn_write(input int p);
    bit a;
    int w0;
    int exp_idx [$];
    w0 = wn;
    i2c_start();
    wr_byte(8'hD2, 0, a); check("addr_ack", a, 1);
    check("busy_on", busy, 1);
    wr_byte(p[7:0], 0, a); check("ptr_ack", a, p < N);
    if (p < N) begin
      mptr = p;
      foreach (tx_q[k]) begin
        wr_byte(tx_q[k], 0, a); check("data_ack", a, 1);
        mregs[mptr] = tx_q[k];
        exp_idx.push_back(mptr);
        mptr = (mptr + 1) % N;
      end
    end else begin
      wr_byte(8'hEE, 0, a); check("data_after_bad_ptr_nack", a, 0);
    end
    i2c_stop();
    check("busy_off", busy, 0);
    check("strobe_cnt", wn - w0, exp_idx.size());
    foreach (exp_idx[k]) check("wr_index", wlog[w0 + k], exp_idx[k]);
    check_regs();
  endtask
  task automatic txn_read(input bit set_ptr, input int p, input int n);
    bit a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      wr_byte(8'hD2, 0, a); check("addr_ack", a, 1);
      wr_byte(p[7:0], 0, a); check("ptr_ack", a, 1);
      mptr = p;
      i2c_start();
    end
    wr_byte(8'hD3, 0, a); check("rd_addr_ack", a, 1);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, d);
      check("rd_data", d, mregs[mptr]);
      mptr = (mptr + 1) % N;
    end
    check("rd_release", sda_oe, 0);
    i2c_stop();
    check("busy_off", busy, 0);
  endtask
  task automatic fill_tx(input int n);
    tx_q.delete();
    for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
  endtask
  initial begin
    bit a, s;
    int o0;
    for (int k = 0; k < N; k++) mregs[k] = 8'h00;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_strobe", wr_strobe, 0);
    check("reset_wr_index", wr_index, 0);
    check("reset_regs", reg_q, 0);
    tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    txn_write(3);
    txn_read(1'b1, 2, 3);
    o0 = oe_cnt;
    i2c_start();
    wr_byte(8'h52, 0, a);
    check("bad_addr_ack", a, 0);
    check("bad_addr_busy", busy, 0);
    check("bad_addr_oe", oe_cnt - o0, 0);
    i2c_stop();
    check_regs();
    tx_q.delete(); tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    txn_write(15);
    txn_write(16);
    txn_read(1'b0, 0, 1);
    tx_q.delete(); tx_q.push_back(8'h00);
    txn_write(9);
    i2c_start();
    wr_byte(8'hD2, 0, a);
    wr_byte(8'h09, 0, a);
    i2c_start();
    wr_byte(8'hD3, 0, a);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, 0, s);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q/2);
    check("oe_mid_read", sda_oe, 1);
    reset = 1'b1; wait_clk(1);
    reset = 1'b0;
    check("oe_after_reset", sda_oe, 0);
    check("regs_after_reset", reg_q, 0);
    check("busy_after_reset", busy, 0);
    for (int k = 0; k < N; k++) mregs[k] = 8'h00;
    mptr = 0;
    scl_m = 1'b0; wait_clk(Q);
    i2c_stop();
    fill_tx(2);
    txn_write(6);
    txn_read(1'b1, 6, 2);
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          fill_tx($urandom_range(1, 4));
          txn_write(($urandom_range(0, 7) == 0) ? $urandom_range(16, 255) : $urandom_range(0, N - 1));
        end
        1: txn_read(1'b1, $urandom_range(0, N - 1), $urandom_range(1, 4));
        default: txn_read(1'b0, 0, $urandom_range(1, 4));
      endcase
    end
`ifdef I2C_GLITCH_FILTER_EN
    o0 = wn;
    i2c_start();
    wr_byte(8'hD2, 0, a);
    wr_byte(8'h05, 0, a);
    wr_byte(8'hC3, 2, a);
    check("short_glitch_ack", a, 1);
    i2c_stop();
    mregs[5] = 8'hC3;
    mptr = 6;
    check("short_glitch_strobe", wn - o0, 1);
    check_regs();
    o0 = wn;
    i2c_start();
    wr_byte(8'hD2, 0, a);
    wr_byte(8'h05, 0, a);
    wr_byte(8'h81, 4, a);
    check("long_glitch_nack", a, 0);
    i2c_stop();
    mptr = 5;
    check("long_glitch_strobe", wn - o0, 0);
    check_regs();
    txn_read(1'b0, 0, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
